// File: rtl/core_instr_fifo_if.sv
// Push/pop bundle between dispatch arbiter, core_instr_fifo and decode.
// Arbiter/decode side is master; the queue is slave.
interface core_instr_fifo_if #(
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic          flush;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output flush,
    output wr_en,
    output wr_data,
    output rd_en,
    input  full,
    input  almost_full,
    input  rd_data,
    input  rd_valid,
    input  empty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  flush,
    input  wr_en,
    input  wr_data,
    input  rd_en,
    output full,
    output almost_full,
    output rd_data,
    output rd_valid,
    output empty,
    output count,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/core_instr_fifo.sv
// Per-core instruction queue between dispatch arbiter and decode.
// INSTR_FIFO_FWFT_EN selects first-word fall-through reads.
module core_instr_fifo #(
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = 28
) (
  input logic               clk,
  input logic               resetn,
  core_instr_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF  = (AW+1)'(AF_THRESH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf_q;
  logic          unf_q;
  logic          full_w;
  logic          empty_w;
  logic          pop_ok;
  logic          push_ok;

  assign full_w  = (cnt == CNT_MAX);
  assign empty_w = (cnt == '0);
  assign pop_ok  = bus.rd_en & ~empty_w;
  assign push_ok = bus.wr_en & (~full_w | pop_ok);

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almost_full = (cnt >= CNT_AF);
  assign bus.count       = cnt;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

  // Storage write; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (resetn && !bus.flush && push_ok)
      mem[wr_ptr] <= bus.wr_data;
  end

  // Pointers and occupancy; flush clears them, sticky flags stay.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.flush) begin
      if (bus.wr_en && full_w && !pop_ok)
        ovf_q <= 1'b1;
      if (bus.rd_en && empty_w)
        unf_q <= 1'b1;
    end
  end

`ifdef INSTR_FIFO_FWFT_EN
  assign bus.rd_data  = empty_w ? 32'h0 : mem[rd_ptr];
  assign bus.rd_valid = ~empty_w;
`else
  logic [31:0] rd_q;
  logic        rv_q;

  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = rv_q;

  // Registered read: one-cycle valid pulse per accepted pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else if (bus.flush) begin
      rv_q <= 1'b0;
    end else begin
      rv_q <= pop_ok;
      if (pop_ok)
        rd_q <= mem[rd_ptr];
    end
  end
`endif

endmodule
